sub32_pipe: RTL and testbench

Four-lane SIMD 32-bit integer subtractor for the SMC integer datapath, the subtract-side companion of the lane adder. Computes `dst = src0 - src1` per lane with saturation, plus per-lane compare status. It is a two-stage pipeline with valid/ready handshakes on both sides, so it can sit between the operand fetch and the writeback queue under backpressure.

---
 rtl/smc_intalu_pkg.sv | 28 ++
 rtl/sub32_lane.sv | 43 ++++
 rtl/sub32_pipe.sv | 136 +++++++++++++
 tb/tb_sub32_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_intalu_pkg.sv
// ---------------------------------------------------------------------------
// smc_intalu_pkg
// Shared constants and helpers for the SMC integer datapath lanes (subtractor
// and lane adder).
//   LANES, W       : lane count and lane width of the SIMD datapath
//   ST_*           : bit positions of the per-lane status nibble
//   SMAX / SMIN    : signed 32-bit clamp limits
//   lane_slice()   : extracts lane idx from a packed LANES*W bus
// ---------------------------------------------------------------------------
package smc_intalu_pkg;

  localparam int LANES = 4;
  localparam int W     = 32;

  localparam int ST_LS  = 0;
  localparam int ST_EQ  = 1;
  localparam int ST_GT  = 2;
  localparam int ST_SAT = 3;

  localparam logic [W-1:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [W-1:0] SMIN = 32'h8000_0000;

  function automatic logic [W-1:0] lane_slice(input logic [LANES*W-1:0] bus,
                                              input int unsigned        idx);
    return bus[idx*W +: W];
  endfunction

endpackage

// File: rtl/sub32_lane.sv
// ---------------------------------------------------------------------------
// sub32_lane
// Combinational stage-1 logic for one subtractor lane.
//   i_a, i_b          : minuend / subtrahend lane values
//   i_sign_a/i_sign_b : per-operand signedness used for extension
//   o_diff            : 2W-bit difference of the extended operands
//   o_cmp             : {gt, eq, ls} at ST_GT/ST_EQ/ST_LS
// ---------------------------------------------------------------------------
module sub32_lane
  import smc_intalu_pkg::*;
(
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_sign_a,
  input  logic           i_sign_b,
  output logic [2*W-1:0] o_diff,
  output logic [2:0]     o_cmp
);

  logic [2*W-1:0] w_ext_a;
  logic [2*W-1:0] w_ext_b;
  logic           w_signed;
  logic           w_lt;
  logic           w_eq;

  always_comb begin
    // Each operand extends by its own flag; the 2W-bit result can never wrap.
    w_ext_a  = {{W{i_sign_a & i_a[W-1]}}, i_a};
    w_ext_b  = {{W{i_sign_b & i_b[W-1]}}, i_b};
    o_diff   = w_ext_a - w_ext_b;

    // Compare mode is shared by both operands: signed if either flag is set.
    w_signed = i_sign_a | i_sign_b;
    w_lt     = w_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
    w_eq     = (i_a == i_b);

    o_cmp        = '0;
    o_cmp[ST_LS] = w_lt;
    o_cmp[ST_EQ] = w_eq;
    o_cmp[ST_GT] = !w_lt && !w_eq;
  end

endmodule

// File: rtl/sub32_pipe.sv
// ---------------------------------------------------------------------------
// sub32_pipe
// Four-lane saturating 32-bit SIMD subtractor, dst = src0 - src1 per lane,
// with per-lane compare status. Two-stage pipeline, valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand beat handshake
//   src0, src1          : packed lanes, lane i at [i*W +: W]
//   sign_s0, sign_s1    : signedness of src0 / src1, captured with the beat
//   out_valid/out_ready : result beat handshake
//   dst                 : saturated differences
//   st                  : status nibble per lane at [i*W +: 4], rest zero
// Handshake: a beat moves whenever valid && ready are both high at a rising
// edge; valid never depends on ready, and a held beat keeps its data stable.
// LANES and W are fixed at the package values.
// ---------------------------------------------------------------------------
module sub32_pipe
  import smc_intalu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] src0,
  input  logic [LANES*W-1:0] src1,
  input  logic               sign_s0,
  input  logic               sign_s1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] dst,
  output logic [LANES*W-1:0] st
);

  // Stage-1 combinational lane results
  logic [2*W-1:0]     w_diff [LANES];
  logic [2:0]         w_cmp  [LANES];
  // Stage-1 registers
  logic [2*W-1:0]     r_diff [LANES];
  logic [2:0]         r_cmp  [LANES];
  logic               r_mode;
  logic               r_v1;
  // Stage-2 registers
  logic [LANES*W-1:0] r_dst;
  logic [LANES*W-1:0] r_st;
  logic               r_ov;

  logic               w_adv1;
  logic               w_adv2;
  logic [W:0]         w_sat  [LANES];
  logic [LANES*W-1:0] w_dst_n;
  logic [LANES*W-1:0] w_st_n;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sub32_lane u_lane (
      .i_a      (lane_slice(src0, g)),
      .i_b      (lane_slice(src1, g)),
      .i_sign_a (sign_s0),
      .i_sign_b (sign_s1),
      .o_diff   (w_diff[g]),
      .o_cmp    (w_cmp[g])
    );
  end

  // Returns {sat, value}. Signed: in range iff the top W+1 bits all agree.
  // Unsigned: only underflow is reachable, the upper clamp is kept for safety.
  function automatic logic [W:0] saturate(input logic [2*W-1:0] d,
                                          input logic           signed_mode);
    logic [W:0] r;
    if (signed_mode) begin
      if ((&d[2*W-1:W-1]) || !(|d[2*W-1:W-1])) r = {1'b0, d[W-1:0]};
      else if (d[2*W-1])                      r = {1'b1, SMIN};
      else                                    r = {1'b1, SMAX};
    end else begin
      if (d[2*W-1])          r = {1'b1, {W{1'b0}}};
      else if (|d[2*W-2:W])  r = {1'b1, {W{1'b1}}};
      else                   r = {1'b0, d[W-1:0]};
    end
    return r;
  endfunction

  assign w_adv2   = !r_ov || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  always_comb begin
    w_dst_n = '0;
    w_st_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sat[i]                 = saturate(r_diff[i], r_mode);
      w_dst_n[i*W +: W]        = w_sat[i][W-1:0];
      w_st_n[i*W + ST_LS]      = r_cmp[i][ST_LS];
      w_st_n[i*W + ST_EQ]      = r_cmp[i][ST_EQ];
      w_st_n[i*W + ST_GT]      = r_cmp[i][ST_GT];
      w_st_n[i*W + ST_SAT]     = w_sat[i][W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_diff[i] <= '0;
        r_cmp[i]  <= '0;
      end
      r_mode <= 1'b0;
      r_v1   <= 1'b0;
      r_dst  <= '0;
      r_st   <= '0;
      r_ov   <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            r_diff[i] <= w_diff[i];
            r_cmp[i]  <= w_cmp[i];
          end
          r_mode <= sign_s0 | sign_s1;
        end
      end
      if (w_adv2) begin
        r_ov <= r_v1;
        if (r_v1) begin
          r_dst <= w_dst_n;
          r_st  <= w_st_n;
        end
      end
    end
  end

  assign out_valid = r_ov;
  assign dst       = r_dst;
  assign st        = r_st;

endmodule

// File: tb/tb_sub32_pipe.sv
// ---------------------------------------------------------------------------
// tb_sub32_pipe
// Self-checking bench for sub32_pipe: directed corner vectors, backpressure,
// mid-operation reset and a 1000-cycle random stream against a plain-arithmetic
// reference model. Inputs change #1 after posedge; outputs are sampled at
// negedge. A beat presented after edge N is captured at N+1 and its result is
// visible after edge N+2.
// ---------------------------------------------------------------------------
module tb_sub32_pipe;

  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int BW    = LANES*W;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] src0 = '0;
  logic [BW-1:0] src1 = '0;
  logic          sign_s0 = 1'b0;
  logic          sign_s1 = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] dst;
  logic [BW-1:0] st;

  always #5 clk = ~clk;

  sub32_pipe #(.LANES(LANES), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src0      (src0),
    .src1      (src1),
    .sign_s0   (sign_s0),
    .sign_s1   (sign_s1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dst       (dst),
    .st        (st)
  );

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  int              n_in     = 0;
  int              n_out    = 0;
  logic [2*BW-1:0] exp_q[$];
  logic [2*BW-1:0] head;

  task automatic check_eq(input string tag, input logic [BW-1:0] got,
                          input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits, subtract, clamp to the mode's
  // range; compares on the 32-bit values in the mode's signedness.
  // Returns {st, dst}.
  function automatic logic [2*BW-1:0] ref_model(input logic [BW-1:0] a_bus,
                                                input logic [BW-1:0] b_bus,
                                                input logic g0, input logic g1);
    logic [BW-1:0] rd;
    logic [BW-1:0] rs;
    logic [31:0]   a, b;
    int            sa, sb;
    longint        ea, eb, d, lo, hi, r, ca, cb;
    logic          sm;
    rd = '0;
    rs = '0;
    sm = g0 | g1;
    for (int i = 0; i < LANES; i++) begin
      a  = a_bus[i*32 +: 32];
      b  = b_bus[i*32 +: 32];
      sa = a;
      sb = b;
      ea = g0 ? longint'(sa) : longint'(a);
      eb = g1 ? longint'(sb) : longint'(b);
      d  = ea - eb;
      if (sm) begin
        lo = 64'hFFFF_FFFF_8000_0000;
        hi = 64'h0000_0000_7FFF_FFFF;
      end else begin
        lo = 0;
        hi = 64'h0000_0000_FFFF_FFFF;
      end
      r = (d < lo) ? lo : ((d > hi) ? hi : d);
      rd[i*32 +: 32] = r[31:0];
      ca = sm ? longint'(sa) : longint'(a);
      cb = sm ? longint'(sb) : longint'(b);
      rs[i*32 + 0] = (ca < cb);
      rs[i*32 + 1] = (ca == cb);
      rs[i*32 + 2] = (ca > cb);
      rs[i*32 + 3] = (r != d);
    end
    return {rs, rd};
  endfunction

  // Monitor: every valid output is checked against the queue head (so a
  // stalled beat is checked each cycle it is held); accepted inputs are queued.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", {{(BW-1){1'b0}}, out_valid}, '0);
        end else begin
          head = exp_q[0];
          check_eq("dst", dst, head[BW-1:0]);
          check_eq("st", st, head[2*BW-1:BW]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(src0, src1, sign_s0, sign_s1));
        n_in++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = rand_lane();
    return v;
  endfunction

  // Presents a beat and returns #1 after the edge that captured it.
  task automatic drive_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                            input logic g0, input logic g1);
    logic ok;
    ok       = 1'b0;
    src0     = a;
    src1     = b;
    sign_s0  = g0;
    sign_s1  = g1;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("in_accept_timeout", '0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", '0, 1);
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready=1: checks latency and exact constants. The sign
  // flags are flipped while the beat is in flight.
  task automatic run_directed(input string tag, input logic [BW-1:0] a,
                              input logic [BW-1:0] b, input logic g0,
                              input logic g1, input logic [BW-1:0] edst,
                              input logic [BW-1:0] est);
    out_ready = 1'b1;
    drive_beat(a, b, g0, g1);
    idle();
    sign_s0 = ~g0;
    sign_s1 = ~g1;
    check_eq({tag, "_lat1"}, {{(BW-1){1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    check_eq({tag, "_lat2"}, {{(BW-1){1'b0}}, out_valid}, 1);
    check_eq({tag, "_dst"}, dst, edst);
    check_eq({tag, "_st"}, st, est);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  logic [BW-1:0] ra, rb;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {{(BW-1){1'b0}}, out_valid}, '0);
    check_eq("rst_dst", dst, '0);
    check_eq("rst_st", st, '0);
    check_eq("rst_in_ready", {{(BW-1){1'b0}}, in_ready}, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned underflow
    run_directed("unsigned",
                 {32'hFFFF_FFFF, 32'h0000_0000, 32'd7, 32'd5},
                 {32'd1, 32'hFFFF_FFFF, 32'd5, 32'd7}, 1'b0, 1'b0,
                 {32'hFFFF_FFFE, 32'h0, 32'd2, 32'h0},
                 {32'h4, 32'h9, 32'h4, 32'h9});

    // Signed saturation
    run_directed("signed",
                 {32'd10, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000},
                 {32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1}, 1'b1, 1'b1,
                 {32'd7, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000},
                 {32'h4, 32'h2, 32'hC, 32'h9});

    // Mixed sign: 0 - (2^32-1) clamps to SMIN, signed compare says gt
    run_directed("mixed",
                 {32'h0, 32'h0, 32'h0, 32'h0},
                 {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 1'b1, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h8000_0000},
                 {32'h2, 32'h2, 32'h2, 32'hC});

    // Backpressure: two beats fill the pipe, third waits 3 stalled cycles
    out_ready = 1'b0;
    drive_beat(rand_bus(), rand_bus(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive_beat(rand_bus(), rand_bus(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    ra       = rand_bus();
    rb       = rand_bus();
    src0     = ra;
    src1     = rb;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {{(BW-1){1'b0}}, in_ready}, '0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_beat(ra, rb, sign_s0, sign_s1);
    drive_beat(rand_bus(), rand_bus(), 1'b0, 1'b1);
    idle();
    wait_drain();
    check_eq("bp_count", n_out, n_in);

    // Reset with both stages full
    out_ready = 1'b0;
    drive_beat(rand_bus(), rand_bus(), 1'b1, 1'b0);
    drive_beat(rand_bus(), rand_bus(), 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {{(BW-1){1'b0}}, out_valid}, '0);
    check_eq("arst_dst", dst, '0);
    check_eq("arst_st", st, '0);
    check_eq("arst_in_ready", {{(BW-1){1'b0}}, in_ready}, 1);
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", {{(BW-1){1'b0}}, out_valid}, '0);
      @(posedge clk);
      #1;
    end
    ra = rand_bus();
    rb = rand_bus();
    head = ref_model(ra, rb, 1'b1, 1'b1);
    run_directed("post_rst", ra, rb, 1'b1, 1'b1, head[BW-1:0], head[2*BW-1:BW]);

    // Throughput: one beat in and one result out every cycle
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      src0     = rand_bus();
      src1     = rand_bus();
      sign_s0  = 1'($urandom_range(0, 1));
      sign_s1  = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("tp_in_ready", {{(BW-1){1'b0}}, in_ready}, 1);
      if (i >= 2) check_eq("tp_out_valid", {{(BW-1){1'b0}}, out_valid}, 1);
      @(posedge clk);
      #1;
    end
    idle();
    wait_drain();
    check_eq("final_count", n_out, n_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
